// File: rtl/fcpu_mmu.sv
// fcpu memory management unit: serialises one load/store/IO op at a time onto the
// 128-bit MIG AXI4 port or the UART byte streams and returns results on a CDB port.
module fcpu_mmu #(
    parameter int                  DATA_W    = 32,
    parameter int                  RSV_ID_W  = 4,
    parameter int                  INSTR_W   = 6,
    parameter int                  CDB_W     = RSV_ID_W + DATA_W,
    parameter logic [INSTR_W-1:0]  OP_LOAD   = 6'd10,
    parameter logic [INSTR_W-1:0]  OP_STORE  = 6'd11,
    parameter logic [INSTR_W-1:0]  OP_INPUT  = 6'd12,
    parameter logic [INSTR_W-1:0]  OP_OUTPUT = 6'd13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RSV_ID_W-1:0] rsv_id,
    input  logic                valid,
    output logic                ready,
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W-1:0]   address,
    input  logic [INSTR_W-1:0]  opcode,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    output logic [7:0]          io_o_data,
    output logic                io_o_valid,
    input  logic                io_o_ready,
    input  logic [7:0]          io_i_data,
    input  logic                io_i_valid,
    output logic                io_i_ready,
    output logic [3:0]          s_axi_awid,
    output logic [27:0]         s_axi_awaddr,
    output logic [7:0]          s_axi_awlen,
    output logic [2:0]          s_axi_awsize,
    output logic [1:0]          s_axi_awburst,
    output logic                s_axi_awlock,
    output logic [3:0]          s_axi_awcache,
    output logic [2:0]          s_axi_awprot,
    output logic [3:0]          s_axi_awqos,
    output logic                s_axi_awvalid,
    input  logic                s_axi_awready,
    output logic [127:0]        s_axi_wdata,
    output logic [15:0]         s_axi_wstrb,
    output logic                s_axi_wlast,
    output logic                s_axi_wvalid,
    input  logic                s_axi_wready,
    input  logic [3:0]          s_axi_bid,
    input  logic [1:0]          s_axi_bresp,
    input  logic                s_axi_bvalid,
    output logic                s_axi_bready,
    output logic [3:0]          s_axi_arid,
    output logic [27:0]         s_axi_araddr,
    output logic [7:0]          s_axi_arlen,
    output logic [2:0]          s_axi_arsize,
    output logic [1:0]          s_axi_arburst,
    output logic                s_axi_arlock,
    output logic [3:0]          s_axi_arcache,
    output logic [2:0]          s_axi_arprot,
    output logic [3:0]          s_axi_arqos,
    output logic                s_axi_arvalid,
    input  logic                s_axi_arready,
    input  logic [3:0]          s_axi_rid,
    input  logic [127:0]        s_axi_rdata,
    input  logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rlast,
    input  logic                s_axi_rvalid,
    output logic                s_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_IO_OUT, S_IO_IN, S_CDB
    } state_t;

    state_t              state_q, state_d;
    logic [RSV_ID_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [25:0]         addr_q, addr_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [1:0]          lane;

    assign lane = addr_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tag_q     <= '0;
            data_q    <= '0;
            result_q  <= '0;
            addr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            result_q  <= result_d;
            addr_q    <= addr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        data_d    = data_q;
        result_d  = result_q;
        addr_d    = addr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    tag_d     = rsv_id;
                    data_d    = data;
                    addr_d    = address[25:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (opcode == OP_STORE)       state_d = S_WR;
                    else if (opcode == OP_LOAD)   state_d = S_RD_ADDR;
                    else if (opcode == OP_OUTPUT) state_d = S_IO_OUT;
                    else if (opcode == OP_INPUT)  state_d = S_IO_IN;
                end
            end
            S_WR: begin
                // AW and W complete independently; leave only when both have
                if (s_axi_awvalid && s_axi_awready) aw_done_d = 1'b1;
                if (s_axi_wvalid && s_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = S_WR_RESP;
            end
            S_WR_RESP: if (s_axi_bvalid) state_d = S_IDLE;
            S_RD_ADDR: if (s_axi_arready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (s_axi_rvalid) begin
                    result_d = s_axi_rdata[{lane, 5'b0} +: DATA_W];
                    state_d  = S_CDB;
                end
            end
            S_IO_OUT: if (io_o_ready) state_d = S_IDLE;
            S_IO_IN: begin
                if (io_i_valid) begin
                    result_d = {{(DATA_W-8){1'b0}}, io_i_data};
                    state_d  = S_CDB;
                end
            end
            S_CDB: if (o_cdb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready         = (state_q == S_IDLE);
    assign o_cdb         = {tag_q, result_q};
    assign o_cdb_valid   = (state_q == S_CDB);
    assign io_o_data     = data_q[7:0];
    assign io_o_valid    = (state_q == S_IO_OUT);
    assign io_i_ready    = (state_q == S_IO_IN);

    assign s_axi_awid    = '0;
    assign s_axi_awaddr  = {addr_q[25:2], 4'b0000};
    assign s_axi_awlen   = '0;
    assign s_axi_awsize  = 3'b100;
    assign s_axi_awburst = 2'b01;
    assign s_axi_awlock  = 1'b0;
    assign s_axi_awcache = '0;
    assign s_axi_awprot  = '0;
    assign s_axi_awqos   = '0;
    assign s_axi_awvalid = (state_q == S_WR) && !aw_done_q;
    assign s_axi_wdata   = {4{data_q}};
    assign s_axi_wstrb   = (state_q == S_WR) ? (16'h000F << {lane, 2'b00}) : '0;
    assign s_axi_wlast   = 1'b1;
    assign s_axi_wvalid  = (state_q == S_WR) && !w_done_q;
    assign s_axi_bready  = (state_q == S_WR_RESP);

    assign s_axi_arid    = '0;
    assign s_axi_araddr  = {addr_q[25:2], 4'b0000};
    assign s_axi_arlen   = '0;
    assign s_axi_arsize  = 3'b100;
    assign s_axi_arburst = 2'b01;
    assign s_axi_arlock  = 1'b0;
    assign s_axi_arcache = '0;
    assign s_axi_arprot  = '0;
    assign s_axi_arqos   = '0;
    assign s_axi_arvalid = (state_q == S_RD_ADDR);
    assign s_axi_rready  = (state_q == S_RD_DATA);

    // Responses carry no information this unit acts on
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rlast,
                             address[DATA_W-1:26]};

endmodule

// File: tb/tb_fcpu_mmu.sv
// Directed bench for fcpu_mmu: small AXI line memory, UART stream stubs and CDB consumer
// driven from one linear initial block.
module tb_fcpu_mmu;

    localparam logic [5:0] OP_LOAD   = 6'd10;
    localparam logic [5:0] OP_STORE  = 6'd11;
    localparam logic [5:0] OP_INPUT  = 6'd12;
    localparam logic [5:0] OP_OUTPUT = 6'd13;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rsv_id;
    logic         valid;
    logic         ready;
    logic [31:0]  data;
    logic [31:0]  address;
    logic [5:0]   opcode;
    logic [35:0]  o_cdb;
    logic         o_cdb_valid;
    logic         o_cdb_ready;
    logic [7:0]   io_o_data;
    logic         io_o_valid;
    logic         io_o_ready;
    logic [7:0]   io_i_data;
    logic         io_i_valid;
    logic         io_i_ready;
    logic [3:0]   s_axi_awid, s_axi_arid;
    logic [27:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]   s_axi_awlen, s_axi_arlen;
    logic [2:0]   s_axi_awsize, s_axi_arsize;
    logic [1:0]   s_axi_awburst, s_axi_arburst;
    logic         s_axi_awlock, s_axi_arlock;
    logic [3:0]   s_axi_awcache, s_axi_arcache;
    logic [2:0]   s_axi_awprot, s_axi_arprot;
    logic [3:0]   s_axi_awqos, s_axi_arqos;
    logic         s_axi_awvalid, s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid, s_axi_bready;
    logic         s_axi_arvalid, s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;

    logic [127:0] mem [16];
    int checks   = 0;
    int failures = 0;

    fcpu_mmu #(
        .DATA_W(32), .RSV_ID_W(4), .INSTR_W(6),
        .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE), .OP_INPUT(OP_INPUT), .OP_OUTPUT(OP_OUTPUT)
    ) dut (
        .clk(clk), .rst(rst), .rsv_id(rsv_id), .valid(valid), .ready(ready),
        .data(data), .address(address), .opcode(opcode),
        .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready),
        .io_o_data(io_o_data), .io_o_valid(io_o_valid), .io_o_ready(io_o_ready),
        .io_i_data(io_i_data), .io_i_valid(io_i_valid), .io_i_ready(io_i_ready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] d,
                         input logic [31:0] a, input logic exp_ready_after);
        chk("ready_idle", ready, 1'b1);
        valid = 1'b1; opcode = op; rsv_id = tag; data = d; address = a;
        @(negedge clk);
        valid = 1'b0; opcode = '0; rsv_id = '0; data = '0; address = '0;
        chk("ready_after_accept", ready, exp_ready_after);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input int unsigned aw_lat, input int unsigned w_lat,
                            input logic [15:0] exp_strb, input logic [27:0] exp_awaddr);
        int unsigned aw_n, w_n;
        logic b_done;
        logic [27:0] aw_cap;
        logic [127:0] wd_cap;
        logic [15:0] ws_cap;
        aw_n = 0; w_n = 0; b_done = 1'b0; aw_cap = '0; wd_cap = '0; ws_cap = '0;
        issue(OP_STORE, 4'd0, d, a, 1'b0);
        for (int c = 0; c < 30 && !b_done; c++) begin
            s_axi_awready = (c >= aw_lat);
            s_axi_wready  = (c >= w_lat);
            s_axi_bvalid  = (aw_n > 0) && (w_n > 0);
            if (s_axi_awvalid && s_axi_awready) begin
                aw_n++;
                aw_cap = s_axi_awaddr;
                chk("awaddr", s_axi_awaddr, exp_awaddr);
                chk("aw_size_burst_len", {s_axi_awsize, s_axi_awburst, s_axi_awlen}, {3'b100, 2'b01, 8'd0});
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_n++;
                wd_cap = s_axi_wdata;
                ws_cap = s_axi_wstrb;
                chk("wdata", s_axi_wdata, {4{d}});
                chk("wstrb", s_axi_wstrb, exp_strb);
                chk("wlast", s_axi_wlast, 1'b1);
            end
            if (s_axi_bvalid && s_axi_bready) begin
                b_done = 1'b1;
                for (int b = 0; b < 16; b++)
                    if (ws_cap[b]) mem[aw_cap[7:4]][8*b +: 8] = wd_cap[8*b +: 8];
            end
            @(negedge clk);
        end
        s_axi_awready = 1'b0; s_axi_wready = 1'b0; s_axi_bvalid = 1'b0;
        chk("store_b_done", b_done, 1'b1);
        chk("aw_count", aw_n, 1);
        chk("w_count", w_n, 1);
        chk("store_ready_back", ready, 1'b1);
        chk("bready_low", s_axi_bready, 1'b0);
        chk("store_no_cdb", o_cdb_valid, 1'b0);
    endtask

    task automatic wait_cdb(input logic [3:0] tag, input logic [31:0] exp,
                            input int unsigned lat);
        logic c_done;
        c_done = 1'b0;
        for (int c = 0; c < 30 && !c_done; c++) begin
            o_cdb_ready = (c >= lat);
            chk("cdb_valid", o_cdb_valid, 1'b1);
            chk("cdb_word", o_cdb, {tag, exp});
            if (o_cdb_valid && o_cdb_ready) c_done = 1'b1;
            @(negedge clk);
        end
        o_cdb_ready = 1'b0;
        chk("cdb_done", c_done, 1'b1);
        chk("cdb_valid_drop", o_cdb_valid, 1'b0);
        chk("cdb_ready_back", ready, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] tag, input int unsigned ar_lat,
                           input int unsigned cdb_lat, input logic [31:0] exp);
        logic ar_seen, r_done;
        logic [27:0] ar_cap;
        ar_seen = 1'b0; r_done = 1'b0; ar_cap = '0;
        issue(OP_LOAD, tag, 32'd0, a, 1'b0);
        for (int c = 0; c < 30 && !r_done; c++) begin
            s_axi_arready = (c >= ar_lat) && !ar_seen;
            s_axi_rvalid  = ar_seen;
            s_axi_rdata   = ar_seen ? mem[ar_cap[7:4]] : '0;
            if (s_axi_rvalid && s_axi_rready) r_done = 1'b1;
            if (s_axi_arvalid && s_axi_arready) begin
                ar_seen = 1'b1;
                ar_cap  = s_axi_araddr;
                chk("araddr", s_axi_araddr, {a[25:2], 4'b0000});
            end
            @(negedge clk);
        end
        s_axi_arready = 1'b0; s_axi_rvalid = 1'b0; s_axi_rdata = '0;
        chk("load_r_done", r_done, 1'b1);
        wait_cdb(tag, exp, cdb_lat);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rsv_id = '0; data = '0; address = '0; opcode = '0;
        o_cdb_ready = 1'b0; io_o_ready = 1'b0; io_i_data = '0; io_i_valid = 1'b0;
        s_axi_awready = 1'b0; s_axi_wready = 1'b0; s_axi_bid = '0; s_axi_bresp = '0;
        s_axi_bvalid = 1'b0; s_axi_arready = 1'b0; s_axi_rid = '0; s_axi_rdata = '0;
        s_axi_rresp = '0; s_axi_rlast = 1'b1; s_axi_rvalid = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valids", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready,
                           s_axi_rready, io_o_valid, io_i_ready, o_cdb_valid}, 8'h00);
        chk("rst_cdb", o_cdb, 36'd0);
        chk("rst_payload", {s_axi_awaddr, s_axi_wstrb, s_axi_wdata, io_o_data}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: store then load back
        do_store(32'd8, 32'h777, 0, 0, 16'h000F, 28'h20);
        do_load(32'd8, 4'd5, 0, 0, 32'h777);

        // 2: overwrite, read twice
        do_store(32'd8, 32'h999, 1, 0, 16'h000F, 28'h20);
        do_load(32'd8, 4'd3, 2, 1, 32'h999);
        do_load(32'd8, 4'd4, 0, 0, 32'h999);

        // 3: neighbouring lanes in the same line
        do_store(32'd9, 32'hA, 2, 0, 16'h00F0, 28'h20);
        do_store(32'd10, 32'hB, 1, 1, 16'h0F00, 28'h20);
        do_load(32'd9, 4'd6, 0, 0, 32'hA);
        do_load(32'd10, 4'd7, 0, 0, 32'hB);
        do_load(32'd8, 4'd8, 0, 0, 32'h999);
        do_store(32'd11, 32'hDEAD_BEEF, 0, 0, 16'hF000, 28'h20);
        do_load(32'd11, 4'd15, 1, 0, 32'hDEAD_BEEF);

        // unknown opcode is swallowed
        issue(6'd63, 4'd1, 32'h55, 32'd4, 1'b1);
        chk("unk_quiet", {s_axi_awvalid, s_axi_arvalid, io_o_valid, io_i_ready, o_cdb_valid}, 5'b0);

        // 4: output byte with delayed ready
        issue(OP_OUTPUT, 4'd0, 32'h141, 32'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            io_o_ready = (c == 3);
            chk("io_o_valid", io_o_valid, 1'b1);
            chk("io_o_data", io_o_data, 8'h41);
            chk("out_no_cdb", o_cdb_valid, 1'b0);
            @(negedge clk);
        end
        io_o_ready = 1'b0;
        chk("io_o_valid_drop", io_o_valid, 1'b0);
        chk("out_ready_back", ready, 1'b1);
        chk("out_no_cdb_after", o_cdb_valid, 1'b0);

        // 5: input byte, CDB back-pressure
        issue(OP_INPUT, 4'd2, 32'd0, 32'd0, 1'b0);
        chk("io_i_ready", io_i_ready, 1'b1);
        io_i_data = 8'h5A; io_i_valid = 1'b1;
        @(negedge clk);
        io_i_data = 8'h00; io_i_valid = 1'b0;
        chk("io_i_ready_drop", io_i_ready, 1'b0);
        wait_cdb(4'd2, 32'h0000005A, 4);

        // 6: split AW/W store, then reset while a read is in flight
        do_store(32'd12, 32'hC, 0, 3, 16'h000F, 28'h30);
        issue(OP_LOAD, 4'd9, 32'd0, 32'd12, 1'b0);
        s_axi_arready = 1'b1;
        chk("rst_case_arvalid", s_axi_arvalid, 1'b1);
        @(negedge clk);
        s_axi_arready = 1'b0;
        chk("rst_case_rready", s_axi_rready, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_valids", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready,
                              s_axi_rready, io_o_valid, io_i_ready, o_cdb_valid}, 8'h00);
        chk("midrst_cdb", o_cdb, 36'd0);
        chk("midrst_payload", {s_axi_araddr, s_axi_wstrb, io_o_data}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_no_cdb", o_cdb_valid, 1'b0);
        do_load(32'd12, 4'd10, 0, 0, 32'hC);
        do_load(32'd9, 4'd11, 0, 2, 32'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
